// File: rtl/tetromino_lock_writer.sv
// Locks a falling tetromino into the playfield: bounds/type check, collision scan
// over four reads, then four writes. GamePkg carries the shared tile type.
package GamePkg;
    typedef enum logic [2:0] {
        BLANK = 3'd0,
        I     = 3'd1,
        O     = 3'd2,
        T     = 3'd3,
        S     = 3'd4,
        Z     = 3'd5,
        J     = 3'd6,
        L     = 3'd7
    } tile_type_t;
endpackage

module tetromino_lock_writer
    import GamePkg::*;
#(
    parameter int NUM_ROWS = 20,
    parameter int NUM_COLS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] tile_row [4],
    input  logic [4:0] tile_col [4],
    input  tile_type_t tile_type,
    output logic       busy,
    output logic       done,
    output logic [1:0] result_code,
    output logic [4:0] rd_row,
    output logic [4:0] rd_col,
    input  tile_type_t rd_data,
    output logic       wr_en,
    output logic [4:0] wr_row,
    output logic [4:0] wr_col,
    output tile_type_t wr_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        READ  = 3'd2,
        LAST  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] CODE_OK   = 2'b00;
    localparam logic [1:0] CODE_OOB  = 2'b01;
    localparam logic [1:0] CODE_COLL = 2'b10;
    localparam logic [1:0] CODE_BAD  = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       coll_q, coll_d;
    logic [1:0] code_q, code_d;
    tile_type_t type_q, type_d;
    logic [4:0] row_q [4];
    logic [4:0] row_d [4];
    logic [4:0] col_q [4];
    logic [4:0] col_d [4];

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] rd_row_q, rd_row_d;
    logic [4:0] rd_col_q, rd_col_d;
    logic       wr_en_q, wr_en_d;
    logic [4:0] wr_row_q, wr_row_d;
    logic [4:0] wr_col_q, wr_col_d;
    tile_type_t wr_data_q, wr_data_d;

    // Unsigned compare, so renderer wrap-around values (31 = -1) land out of range.
    function automatic logic any_oob(input logic [4:0] r [4], input logic [4:0] c [4]);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((32'(r[k]) >= 32'(NUM_ROWS)) || (32'(c[k]) >= 32'(NUM_COLS))) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Next-state logic; outputs are registered from the next state so they line up with it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        coll_d  = coll_q;
        code_d  = code_q;
        type_d  = type_q;
        for (int k = 0; k < 4; k++) begin
            row_d[k] = row_q[k];
            col_d[k] = col_q[k];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < 4; k++) begin
                        row_d[k] = tile_row[k];
                        col_d[k] = tile_col[k];
                    end
                    type_d  = tile_type;
                    idx_d   = 2'd0;
                    coll_d  = 1'b0;
                    code_d  = CODE_OK;
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (type_q == BLANK) begin
                    code_d  = CODE_BAD;
                    state_d = DONE;
                end else if (any_oob(row_q, col_q)) begin
                    code_d  = CODE_OOB;
                    state_d = DONE;
                end else begin
                    idx_d   = 2'd0;
                    state_d = READ;
                end
            end
            READ: begin
                // Data for the read issued last cycle arrives now (none yet at idx 0).
                if ((idx_q != 2'd0) && (rd_data != BLANK)) begin
                    coll_d = 1'b1;
                end else begin
                    coll_d = coll_q;
                end
                if (idx_q == 2'd3) begin
                    idx_d   = 2'd0;
                    state_d = LAST;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = READ;
                end
            end
            LAST: begin
                if (coll_q || (rd_data != BLANK)) begin
                    coll_d  = 1'b1;
                    code_d  = CODE_COLL;
                    state_d = DONE;
                end else begin
                    idx_d   = 2'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == 2'd3) begin
                    idx_d   = 2'd0;
                    code_d  = CODE_OK;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);

        if (state_d == READ) begin
            rd_row_d = row_q[idx_d];
            rd_col_d = col_q[idx_d];
        end else begin
            rd_row_d = 5'd0;
            rd_col_d = 5'd0;
        end

        if (state_d == WRITE) begin
            wr_en_d   = 1'b1;
            wr_row_d  = row_q[idx_d];
            wr_col_d  = col_q[idx_d];
            wr_data_d = type_q;
        end else begin
            wr_en_d   = 1'b0;
            wr_row_d  = 5'd0;
            wr_col_d  = 5'd0;
            wr_data_d = BLANK;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            coll_q    <= 1'b0;
            code_q    <= CODE_OK;
            type_q    <= BLANK;
            for (int k = 0; k < 4; k++) begin
                row_q[k] <= 5'd0;
                col_q[k] <= 5'd0;
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_row_q  <= 5'd0;
            rd_col_q  <= 5'd0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= 5'd0;
            wr_col_q  <= 5'd0;
            wr_data_q <= BLANK;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            coll_q    <= coll_d;
            code_q    <= code_d;
            type_q    <= type_d;
            for (int k = 0; k < 4; k++) begin
                row_q[k] <= row_d[k];
                col_q[k] <= col_d[k];
            end
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_code = code_q;
    assign rd_row      = rd_row_q;
    assign rd_col      = rd_col_q;
    assign wr_en       = wr_en_q;
    assign wr_row      = wr_row_q;
    assign wr_col      = wr_col_q;
    assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_tetromino_lock_writer.sv
// Directed bench for tetromino_lock_writer with a behavioural playfield memory
// (one-cycle registered read, write on wr_en).
module tb_tetromino_lock_writer;
    import GamePkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] tile_row [4];
    logic [4:0] tile_col [4];
    tile_type_t tile_type;
    logic       busy;
    logic       done;
    logic [1:0] result_code;
    logic [4:0] rd_row;
    logic [4:0] rd_col;
    tile_type_t rd_data;
    logic       wr_en;
    logic [4:0] wr_row;
    logic [4:0] wr_col;
    tile_type_t wr_data;

    tetromino_lock_writer #(.NUM_ROWS(20), .NUM_COLS(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .tile_row(tile_row), .tile_col(tile_col), .tile_type(tile_type),
        .busy(busy), .done(done), .result_code(result_code),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    tile_type_t pf [32][32];
    logic       clr;
    logic       pl_en;
    logic [4:0] pl_r;
    logic [4:0] pl_c;
    tile_type_t pl_d;

    // Playfield model: clear, preload, or DUT write; read data returns one cycle later.
    always @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < 32; r++) begin
                for (int c = 0; c < 32; c++) begin
                    pf[r][c] <= BLANK;
                end
            end
        end else if (pl_en) begin
            pf[pl_r][pl_c] <= pl_d;
        end else if (wr_en) begin
            pf[wr_row][wr_col] <= wr_data;
        end
        rd_data <= pf[rd_row][rd_col];
    end

    int n_cmp = 0;
    int n_bad = 0;

    int          done_cyc;
    int          done_cnt;
    int          busy_last;
    int          idle_wr_bad;
    logic [15:0] wr_mask;
    logic [15:0] rd_mask;
    logic [1:0]  code_at_done;
    logic [4:0]  wr_r_log [16];
    logic [4:0]  wr_c_log [16];
    tile_type_t  wr_d_log [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_tiles(input logic [4:0] r0, input logic [4:0] c0,
                             input logic [4:0] r1, input logic [4:0] c1,
                             input logic [4:0] r2, input logic [4:0] c2,
                             input logic [4:0] r3, input logic [4:0] c3,
                             input tile_type_t ty);
        tile_row[0] = r0; tile_col[0] = c0;
        tile_row[1] = r1; tile_col[1] = c1;
        tile_row[2] = r2; tile_col[2] = c2;
        tile_row[3] = r3; tile_col[3] = c3;
        tile_type   = ty;
    endtask

    task automatic clear_board();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic preload(input logic [4:0] r, input logic [4:0] c, input tile_type_t d);
        pl_en = 1'b1; pl_r = r; pl_c = c; pl_d = d;
        tick();
        pl_en = 1'b0;
    endtask

    // start is high during cycle 0; cycles 1..15 are observed, with optional extra start / rst.
    task automatic run_lock(input int restart_at, input int rst_at);
        done_cyc = -1; done_cnt = 0; busy_last = -1; idle_wr_bad = 0;
        wr_mask = 16'h0000; rd_mask = 16'h0000; code_at_done = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 16; c++) begin
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
                code_at_done = result_code;
            end
            if (busy) busy_last = c;
            if (wr_en) begin
                wr_mask[c]  = 1'b1;
                wr_r_log[c] = wr_row;
                wr_c_log[c] = wr_col;
                wr_d_log[c] = wr_data;
            end else if ((wr_row != 5'd0) || (wr_col != 5'd0) || (wr_data != BLANK)) begin
                idle_wr_bad++;
            end
            if ((rd_row != 5'd0) || (rd_col != 5'd0)) rd_mask[c] = 1'b1;
            rst   = (c == rst_at);
            start = (c == restart_at);
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0; pl_en = 1'b0;
        pl_r = 5'd0; pl_c = 5'd0; pl_d = BLANK;
        set_tiles(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, BLANK);
        tick();
        tick();
        clear_board();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_code", 32'(result_code), 32'd0);
        chk("rst_rd_addr", {22'd0, rd_row, rd_col}, 32'd0);

        // start coincident with rst is ignored
        set_tiles(5'd5, 5'd4, 5'd5, 5'd3, 5'd4, 5'd4, 5'd5, 5'd5, T);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy0", 32'(busy), 32'd0);
        tick();
        chk("rst_start_busy1", 32'(busy), 32'd0);

        // OK lock of a T on an empty board
        run_lock(-1, -1);
        chk("ok_done_cyc", 32'(done_cyc), 32'd11);
        chk("ok_done_cnt", 32'(done_cnt), 32'd1);
        chk("ok_code", 32'(code_at_done), 32'd0);
        chk("ok_wr_mask", 32'(wr_mask), 32'h0780);
        chk("ok_rd_mask", 32'(rd_mask), 32'h003C);
        chk("ok_busy_last", 32'(busy_last), 32'd11);
        chk("ok_idle_wr", 32'(idle_wr_bad), 32'd0);
        chk("ok_wr7", {19'd0, wr_r_log[7], wr_c_log[7], 3'(wr_d_log[7])}, {19'd0, 5'd5, 5'd4, 3'(T)});
        chk("ok_wr8", {19'd0, wr_r_log[8], wr_c_log[8], 3'(wr_d_log[8])}, {19'd0, 5'd5, 5'd3, 3'(T)});
        chk("ok_wr9", {19'd0, wr_r_log[9], wr_c_log[9], 3'(wr_d_log[9])}, {19'd0, 5'd4, 5'd4, 3'(T)});
        chk("ok_wr10", {19'd0, wr_r_log[10], wr_c_log[10], 3'(wr_d_log[10])}, {19'd0, 5'd5, 5'd5, 3'(T)});
        chk("ok_pf_44", 32'(pf[4][4]), 32'(T));
        chk("ok_code_held", 32'(result_code), 32'd0);

        // Collision with (4,4)=I preloaded
        clear_board();
        preload(5'd4, 5'd4, I);
        run_lock(-1, -1);
        chk("coll_done_cyc", 32'(done_cyc), 32'd7);
        chk("coll_code", 32'(code_at_done), 32'd2);
        chk("coll_wr_mask", 32'(wr_mask), 32'h0000);
        chk("coll_pf_55", 32'(pf[5][5]), 32'(BLANK));
        chk("coll_code_held", 32'(result_code), 32'd2);

        // Wrapped row 31 is out of bounds, no reads issued
        clear_board();
        set_tiles(5'd31, 5'd4, 5'd0, 5'd4, 5'd0, 5'd5, 5'd1, 5'd4, S);
        run_lock(-1, -1);
        chk("oob_done_cyc", 32'(done_cyc), 32'd2);
        chk("oob_code", 32'(code_at_done), 32'd1);
        chk("oob_rd_mask", 32'(rd_mask), 32'h0000);
        chk("oob_wr_mask", 32'(wr_mask), 32'h0000);

        // BLANK type outranks an out-of-range column
        set_tiles(5'd3, 5'd12, 5'd3, 5'd1, 5'd3, 5'd2, 5'd3, 5'd3, BLANK);
        run_lock(-1, -1);
        chk("bad_done_cyc", 32'(done_cyc), 32'd2);
        chk("bad_code", 32'(code_at_done), 32'd3);

        // Row 20 and column 10 are just past the edge
        set_tiles(5'd20, 5'd0, 5'd19, 5'd0, 5'd18, 5'd0, 5'd17, 5'd0, Z);
        run_lock(-1, -1);
        chk("row20_code", 32'(code_at_done), 32'd1);
        set_tiles(5'd0, 5'd10, 5'd0, 5'd9, 5'd0, 5'd8, 5'd0, 5'd7, Z);
        run_lock(-1, -1);
        chk("col10_code", 32'(code_at_done), 32'd1);

        // Corner cells (19,9) and (0,0) are legal
        set_tiles(5'd19, 5'd9, 5'd19, 5'd8, 5'd18, 5'd9, 5'd0, 5'd0, O);
        run_lock(-1, -1);
        chk("edge_done_cyc", 32'(done_cyc), 32'd11);
        chk("edge_code", 32'(code_at_done), 32'd0);
        chk("edge_pf_19_9", 32'(pf[19][9]), 32'(O));
        chk("edge_pf_0_0", 32'(pf[0][0]), 32'(O));

        // Second start during READ is ignored
        clear_board();
        set_tiles(5'd5, 5'd4, 5'd5, 5'd3, 5'd4, 5'd4, 5'd5, 5'd5, T);
        run_lock(3, -1);
        chk("restart_done_cnt", 32'(done_cnt), 32'd1);
        chk("restart_done_cyc", 32'(done_cyc), 32'd11);
        chk("restart_busy_last", 32'(busy_last), 32'd11);

        // Reset at cycle 8 of an OK lock: tiles 0 and 1 only
        clear_board();
        run_lock(-1, 8);
        chk("mrst_wr_mask", 32'(wr_mask), 32'h0180);
        chk("mrst_done_cnt", 32'(done_cnt), 32'd0);
        chk("mrst_busy_last", 32'(busy_last), 32'd8);
        chk("mrst_pf_54", 32'(pf[5][4]), 32'(T));
        chk("mrst_pf_53", 32'(pf[5][3]), 32'(T));
        chk("mrst_pf_44", 32'(pf[4][4]), 32'(BLANK));
        chk("mrst_pf_55", 32'(pf[5][5]), 32'(BLANK));
        chk("mrst_code", 32'(result_code), 32'd0);

        // Fresh lock after reset completes normally on an empty board
        clear_board();
        run_lock(-1, -1);
        chk("post_done_cyc", 32'(done_cyc), 32'd11);
        chk("post_code", 32'(code_at_done), 32'd0);
        chk("post_wr_mask", 32'(wr_mask), 32'h0780);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
